wptr_full_ctrl: RTL and testbench
=================================

// Module: wptr_full_ctrl
// PURPOSE
//  Write-domain pointer/flag engine of the async FIFO; counterpart of the read-pointer/empty block.
//  Holds the binary write pointer and drives its Gray copy to the write->read synchronizer.
//  Compares against the read Gray pointer synchronized into w_clk to produce full, almost-full,
//  a fill level and a sticky overflow error. Drives write address/enable to the dual-port memory.
// PARAMETERS
//  ADDR_W     9  memory address width; DEPTH = 2**ADDR_W (512); pointers are ADDR_W+1 bits
//  AF_MARGIN  4  f_almost_full asserts when level >= DEPTH-AF_MARGIN
// PORTS
//  w_clk           in   1         write clock; the only clock
//  wrst            in   1         asynchronous, active-high reset
//  w_en            in   1         write request from producer
//  rptr_gray_sync  in   ADDR_W+1  read Gray pointer, already 2-flop synchronized into w_clk
//  ovf_clr         in   1         clears sticky overflow
//  w_accept        out  1         combinational w_en & !f_full; memory write enable
//  waddr           out  ADDR_W    wptr[ADDR_W-1:0]; memory write address
//  wptr            out  ADDR_W+1  registered binary write pointer
//  wptr_gray       out  ADDR_W+1  registered Gray write pointer, to synchronizer
//  f_full          out  1         registered full flag
//  f_almost_full   out  1         registered almost-full flag
//  wlevel          out  ADDR_W+1  registered occupancy estimate, 0..DEPTH
//  overflow        out  1         sticky: write attempted while full
// BEHAVIOUR
//  Reset (wrst=1, async): wptr=0, wptr_gray=0, f_full=0, f_almost_full=0, wlevel=0, overflow=0.
//   Mid-operation reset takes effect immediately, no clock needed; w_accept follows (w_en & 1).
//  Next-state (combinational): b_next = wptr + (w_en & !f_full); g_next = (b_next>>1) ^ b_next.
//  Every w_clk edge: wptr<=b_next; wptr_gray<=g_next; waddr always = wptr low ADDR_W bits.
//  Full (look-ahead): full_next = (g_next == {~rptr_gray_sync[MSB:MSB-1], rptr_gray_sync[MSB-2:0]}).
//   f_full<=full_next, so f_full is high the cycle after the DEPTH-th unread write is accepted;
//   no extra write can be accepted in that cycle.
//  Level: rbin = Gray-to-binary of rptr_gray_sync (rbin[i] = ^rptr_gray_sync[MSB:i]).
//   level_next = (b_next - rbin) mod 2**(ADDR_W+1); wlevel<=level_next.
//   f_almost_full <= (level_next >= DEPTH-AF_MARGIN). Level/full are pessimistic: reads are seen
//   only after synchronizer delay, never optimistic.
//  Full deassert: only when rptr_gray_sync changes; f_full drops on the first w_clk edge after.
//  Overflow: set on edge where w_en & f_full; cleared by ovf_clr; same-cycle set and clr -> set wins.
//   Rejected write changes nothing else (wptr, wptr_gray, wlevel hold).
//  Wrap-around: pointers wrap 2**(ADDR_W+1)-1 -> 0 naturally; MSB flip distinguishes full from empty.
//  Gray output changes at most one bit per w_clk edge (CDC safety; checked by assertion).
//  rptr_gray_sync is treated as an arbitrary value each cycle; no assumption of monotonic steps
//   beyond Gray single-bit change.
// TESTING
//  T1 reset: 20 writes then wrst pulse between edges -> all registered outputs 0 immediately,
//     f_full=0, wlevel=0; writes resume from waddr=0 after release.
//  T2 fill: rptr_gray_sync=0, w_en=1 continuous -> f_almost_full=1 when wlevel reaches 508,
//     f_full=1 with wptr=10'h200, wlevel=512 exactly after 512th accepted write.
//  T3 overflow: hold w_en after full -> w_accept=0, wptr stays 10'h200, overflow=1 and stays 1;
//     ovf_clr pulse with w_en=0 -> 0; ovf_clr with w_en=1 while full -> remains 1.
//  T4 drain/unfull: full at wptr=10'h200, set rptr_gray_sync=gray(1) -> f_full=0 next edge,
//     wlevel=511; one write accepted, then f_full=1 again with wptr=10'h201.
//  T5 wrap: rptr_gray_sync=gray(10'h3F0), wptr walked to 10'h3FF then +1 -> wptr=10'h000,
//     wptr_gray=0, wlevel=16 then 17; full at wptr=10'h1F0 (MSB flipped, level 512).
//  T6 level: wptr=100, rptr_gray_sync=gray(40), w_en=0 -> wlevel=60, f_almost_full=0; assert
//     wptr_gray Hamming distance <=1 per edge across all tests.

Source files
------------

// File: rtl/wptr_full_ctrl_if.sv
`timescale 1ns/1ps
// Write-side bundle of the async FIFO pointer engine: producer request, synchronized
// read pointer and overflow clear in; accept, memory address, pointers, flags and level out.
// master = producer/test side, slave = the pointer engine itself.
interface wptr_full_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              w_en;
  logic [ADDR_W:0]   rptr_gray_sync;
  logic              ovf_clr;
  logic              w_accept;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   wptr_gray;
  logic              f_full;
  logic              f_almost_full;
  logic [ADDR_W:0]   wlevel;
  logic              overflow;

  modport master (
    output w_en, rptr_gray_sync, ovf_clr,
    input  w_accept, waddr, wptr, wptr_gray, f_full, f_almost_full, wlevel, overflow
  );

  modport slave (
    input  w_en, rptr_gray_sync, ovf_clr,
    output w_accept, waddr, wptr, wptr_gray, f_full, f_almost_full, wlevel, overflow
  );
endinterface

// File: rtl/wptr_full_ctrl.sv
`timescale 1ns/1ps
// Write-domain pointer/flag engine of the async FIFO (binary + Gray write pointer, full/almost-full, level, overflow).
// Latency: w_accept is combinational; pointers, flags and level update on the w_clk edge that takes the write.
// Backpressure: f_full gates w_accept; a write requested while full is dropped and latches sticky overflow.
module wptr_full_ctrl #(
  parameter int ADDR_W    = 9,
  parameter int AF_MARGIN = 4
) (
  input  logic              w_clk,
  input  logic              wrst,
  wptr_full_ctrl_if.slave   bus
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF_THRESH = (ADDR_W+1)'(DEPTH - AF_MARGIN);

  logic [ADDR_W:0] r_wptr;
  logic [ADDR_W:0] r_wptr_gray;
  logic            r_full;
  logic            r_almost_full;
  logic [ADDR_W:0] r_wlevel;
  logic            r_overflow;

  logic            w_inc;
  logic [ADDR_W:0] w_b_next;
  logic [ADDR_W:0] w_g_next;
  logic [ADDR_W:0] w_rgray_full;
  logic [ADDR_W:0] w_rbin;
  logic [ADDR_W:0] w_level_next;
  logic            w_full_next;
  logic            w_af_next;

  // A write is taken only while not full; the registered full flag is the sole gate.
  assign w_inc    = bus.w_en & ~r_full;
  assign w_b_next = r_wptr + {{ADDR_W{1'b0}}, w_inc};
  assign w_g_next = w_b_next ^ (w_b_next >> 1);

  // Full when the next write pointer equals the read pointer with its two Gray MSBs inverted,
  // i.e. binary pointers differ by exactly DEPTH (MSB flipped, low bits equal).
  assign w_rgray_full = {~bus.rptr_gray_sync[ADDR_W:ADDR_W-1], bus.rptr_gray_sync[ADDR_W-2:0]};
  assign w_full_next  = (w_g_next == w_rgray_full);

  // Gray-to-binary of the synchronized read pointer: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_rbin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      w_rbin[i] = ^(bus.rptr_gray_sync >> i);
    end
  end

  // Modulo subtraction handles pointer wrap; the stale read pointer makes this an over-estimate only.
  assign w_level_next = w_b_next - w_rbin;
  assign w_af_next    = (w_level_next >= AF_THRESH);

  // Pointer, flag, level and overflow state; overflow set beats a same-cycle clear.
  always_ff @(posedge w_clk or posedge wrst) begin
    if (wrst) begin
      r_wptr        <= '0;
      r_wptr_gray   <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_wlevel      <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_wptr        <= w_b_next;
      r_wptr_gray   <= w_g_next;
      r_full        <= w_full_next;
      r_almost_full <= w_af_next;
      r_wlevel      <= w_level_next;
      if (bus.w_en & r_full) begin
        r_overflow <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign bus.w_accept      = w_inc;
  assign bus.waddr         = r_wptr[ADDR_W-1:0];
  assign bus.wptr          = r_wptr;
  assign bus.wptr_gray     = r_wptr_gray;
  assign bus.f_full        = r_full;
  assign bus.f_almost_full = r_almost_full;
  assign bus.wlevel        = r_wlevel;
  assign bus.overflow      = r_overflow;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
`timescale 1ns/1ps
// Bench for the async FIFO write pointer/full engine: reset, fill, overflow, unfull, wrap and level.
// Directed table vectors plus hand sequences; every edge also checks the Gray pointer moves at most one bit.
module tb_wptr_full_ctrl;

  localparam int ADDR_W = 9;

  logic w_clk;
  logic wrst;

  wptr_full_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  wptr_full_ctrl #(.ADDR_W(ADDR_W), .AF_MARGIN(4)) dut (
    .w_clk (w_clk),
    .wrst  (wrst),
    .bus   (bus)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int n_cmp;
  int n_bad;
  logic [9:0] pg;

  typedef struct {
    logic       w_en;
    logic [9:0] rbin;
    logic       ovf_clr;
    logic       e_acc;
    logic [9:0] e_wptr;
    logic       e_full;
    logic       e_af;
    logic [9:0] e_lvl;
    logic       e_ovf;
  } vec_t;

  vec_t vt[12];

  function automatic logic [9:0] gray(input logic [9:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge w_clk);
    #1;
    chk("gray_1bit_step", 32'($countones(bus.wptr_gray ^ pg) <= 1), 32'd1);
    pg = bus.wptr_gray;
  endtask

  task automatic check_state(input string tag, input logic [9:0] wp, input logic full,
                             input logic af, input logic [9:0] lvl, input logic ovf);
    chk({tag, "_wptr"},  32'(bus.wptr), 32'(wp));
    chk({tag, "_gray"},  32'(bus.wptr_gray), 32'(gray(wp)));
    chk({tag, "_waddr"}, 32'(bus.waddr), 32'(wp[8:0]));
    chk({tag, "_full"},  32'(bus.f_full), 32'(full));
    chk({tag, "_af"},    32'(bus.f_almost_full), 32'(af));
    chk({tag, "_lvl"},   32'(bus.wlevel), 32'(lvl));
    chk({tag, "_ovf"},   32'(bus.overflow), 32'(ovf));
  endtask

  // Reset pulse placed mid-cycle, away from clock edges.
  task automatic pulse_reset();
    wrst = 1'b1;
    #2;
    wrst = 1'b0;
    pg = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    pg = '0;

    // idx: w_en rbin ovf_clr | acc wptr full af lvl ovf   (start: wptr=100, rptr=0)
    vt[0]  = '{1'b0, 10'd40,   1'b0, 1'b0, 10'd100, 1'b0, 1'b0, 10'd60,  1'b0};
    vt[1]  = '{1'b1, 10'd40,   1'b0, 1'b1, 10'd101, 1'b0, 1'b0, 10'd61,  1'b0};
    vt[2]  = '{1'b1, 10'd101,  1'b0, 1'b1, 10'd102, 1'b0, 1'b0, 10'd1,   1'b0};
    vt[3]  = '{1'b0, 10'd102,  1'b0, 1'b0, 10'd102, 1'b0, 1'b0, 10'd0,   1'b0};
    vt[4]  = '{1'b0, 10'd1022, 1'b0, 1'b0, 10'd102, 1'b0, 1'b0, 10'd104, 1'b0};
    vt[5]  = '{1'b0, 10'd618,  1'b0, 1'b0, 10'd102, 1'b0, 1'b1, 10'd508, 1'b0};
    vt[6]  = '{1'b0, 10'd619,  1'b0, 1'b0, 10'd102, 1'b0, 1'b0, 10'd507, 1'b0};
    vt[7]  = '{1'b0, 10'd614,  1'b0, 1'b0, 10'd102, 1'b1, 1'b1, 10'd512, 1'b0};
    vt[8]  = '{1'b1, 10'd614,  1'b0, 1'b0, 10'd102, 1'b1, 1'b1, 10'd512, 1'b1};
    vt[9]  = '{1'b0, 10'd614,  1'b1, 1'b0, 10'd102, 1'b1, 1'b1, 10'd512, 1'b0};
    vt[10] = '{1'b0, 10'd615,  1'b0, 1'b0, 10'd102, 1'b0, 1'b1, 10'd511, 1'b0};
    vt[11] = '{1'b1, 10'd615,  1'b0, 1'b1, 10'd103, 1'b1, 1'b1, 10'd512, 1'b0};

    // Power-on reset, checked before any clock edge.
    wrst = 1'b1;
    bus.w_en = 1'b0;
    bus.rptr_gray_sync = '0;
    bus.ovf_clr = 1'b0;
    #2;
    check_state("por", 10'd0, 1'b0, 1'b0, 10'd0, 1'b0);
    @(posedge w_clk);
    #1;
    wrst = 1'b0;

    // T1: 20 writes, async reset mid-cycle, then writes resume at address 0.
    bus.w_en = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check_state("t1_pre", 10'd20, 1'b0, 1'b0, 10'd20, 1'b0);
    wrst = 1'b1;
    #1;
    check_state("t1_rst", 10'd0, 1'b0, 1'b0, 10'd0, 1'b0);
    chk("t1_rst_accept", 32'(bus.w_accept), 32'd1);
    #1;
    wrst = 1'b0;
    pg = '0;
    chk("t1_resume_waddr", 32'(bus.waddr), 32'd0);
    step();
    check_state("t1_post", 10'd1, 1'b0, 1'b0, 10'd1, 1'b0);

    // Table vectors starting from wptr=100 with read pointer at 0.
    pulse_reset();
    bus.w_en = 1'b1;
    for (int i = 0; i < 100; i++) step();
    check_state("t6_walk", 10'd100, 1'b0, 1'b0, 10'd100, 1'b0);
    for (int i = 0; i < 12; i++) begin
      bus.w_en = vt[i].w_en;
      bus.rptr_gray_sync = gray(vt[i].rbin);
      bus.ovf_clr = vt[i].ovf_clr;
      #1;
      chk($sformatf("vec%0d_accept", i), 32'(bus.w_accept), 32'(vt[i].e_acc));
      step();
      check_state($sformatf("vec%0d", i), vt[i].e_wptr, vt[i].e_full, vt[i].e_af,
                  vt[i].e_lvl, vt[i].e_ovf);
    end
    bus.ovf_clr = 1'b0;
    bus.w_en = 1'b0;

    // T2: fill from empty with the reader parked at 0.
    pulse_reset();
    bus.rptr_gray_sync = '0;
    bus.w_en = 1'b1;
    for (int k = 1; k <= 512; k++) begin
      step();
      if (k == 507) check_state("t2_507", 10'd507, 1'b0, 1'b0, 10'd507, 1'b0);
      if (k == 508) check_state("t2_508", 10'd508, 1'b0, 1'b1, 10'd508, 1'b0);
      if (k == 511) check_state("t2_511", 10'd511, 1'b0, 1'b1, 10'd511, 1'b0);
    end
    check_state("t2_full", 10'h200, 1'b1, 1'b1, 10'd512, 1'b0);

    // T3: keep writing while full, then clear overflow with and without a colliding write.
    chk("t3_accept_full", 32'(bus.w_accept), 32'd0);
    step();
    check_state("t3_ovf", 10'h200, 1'b1, 1'b1, 10'd512, 1'b1);
    step();
    check_state("t3_ovf_sticky", 10'h200, 1'b1, 1'b1, 10'd512, 1'b1);
    bus.w_en = 1'b0;
    bus.ovf_clr = 1'b1;
    step();
    check_state("t3_clr", 10'h200, 1'b1, 1'b1, 10'd512, 1'b0);
    bus.w_en = 1'b1;
    step();
    check_state("t3_set_wins", 10'h200, 1'b1, 1'b1, 10'd512, 1'b1);
    bus.ovf_clr = 1'b0;

    // T4: one read becomes visible, one more write fits, then full again.
    bus.w_en = 1'b0;
    bus.rptr_gray_sync = gray(10'd1);
    step();
    check_state("t4_unfull", 10'h200, 1'b0, 1'b1, 10'd511, 1'b1);
    bus.w_en = 1'b1;
    #1;
    chk("t4_accept", 32'(bus.w_accept), 32'd1);
    step();
    check_state("t4_refull", 10'h201, 1'b1, 1'b1, 10'd512, 1'b1);
    chk("t4_accept_refull", 32'(bus.w_accept), 32'd0);

    // T5: walk to 10'h3FF with the reader trailing closely, then wrap and fill to full.
    pulse_reset();
    bus.w_en = 1'b1;
    for (int i = 0; i < 1023; i++) begin
      bus.rptr_gray_sync = gray(10'(i));
      step();
    end
    check_state("t5_top", 10'h3FF, 1'b0, 1'b0, 10'd1, 1'b0);
    bus.rptr_gray_sync = gray(10'h3F0);
    step();
    check_state("t5_wrap", 10'h000, 1'b0, 1'b0, 10'd16, 1'b0);
    step();
    check_state("t5_wrap1", 10'h001, 1'b0, 1'b0, 10'd17, 1'b0);
    for (int i = 0; i < 10'h1EE; i++) step();
    check_state("t5_nearfull", 10'h1EF, 1'b0, 1'b1, 10'd511, 1'b0);
    step();
    check_state("t5_full", 10'h1F0, 1'b1, 1'b1, 10'd512, 1'b0);
    chk("t5_accept_full", 32'(bus.w_accept), 32'd0);
    bus.w_en = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
